// File: rtl/mem_unit_sb.sv
// mem_unit_sb
//   MEM-stage data memory unit. Stores retire into a small FIFO store buffer
//   and reach the single-port RAM later, one entry per cycle in which no load
//   owns the port. Loads take one cycle and support byte/half/word accesses
//   with sign or zero extension. Misaligned requests are dropped and flagged.
//
// Ports
//   Clk                 clock, all state on the rising edge
//   Rst_n               asynchronous active-low reset
//   EX_MEM_ALUResult    byte address (word index = [AW+1:2], upper bits wrap)
//   EX_MEM_rt_val       store data, value in the low-order bits
//   EX_MEM_MemWrite     store request
//   EX_MEM_MemRead      load request (ignored when MemWrite is also set)
//   EX_MEM_HalfControl  halfword access
//   EX_MEM_ByteControl  byte access (wins over HalfControl); neither = word
//   EX_MEM_Unsigned     load zero-extends when 1, sign-extends when 0
//   MEM_Stall           request not accepted this cycle, hold inputs
//   MEM_ReadData        extended load data, held until the next accepted load
//   MEM_ReadValid       pulse, the cycle after a load is accepted
//   MEM_AddrError       pulse, the cycle after a misaligned request
//   MEM_SBEmpty         store buffer holds no entries
module mem_unit_sb #(
  parameter string memory_file = "data",
  parameter int    MEM_DEPTH   = 1024,
  parameter int    SB_DEPTH    = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] EX_MEM_ALUResult,
  input  logic [31:0] EX_MEM_rt_val,
  input  logic        EX_MEM_MemWrite,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_HalfControl,
  input  logic        EX_MEM_ByteControl,
  input  logic        EX_MEM_Unsigned,
  output logic        MEM_Stall,
  output logic [31:0] MEM_ReadData,
  output logic        MEM_ReadValid,
  output logic        MEM_AddrError,
  output logic        MEM_SBEmpty
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(SB_DEPTH + 1);
  localparam int PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic          unused_addr_bits;
  logic          misaligned;
  logic          store_req;
  logic          load_req;
  logic [3:0]    store_be;
  logic [31:0]   store_data;

  assign lane             = EX_MEM_ALUResult[1:0];
  assign word_idx         = EX_MEM_ALUResult[AW+1:2];
  assign unused_addr_bits = ^EX_MEM_ALUResult[31:AW+2];

  always_comb begin
    misaligned = 1'b0;
    if (EX_MEM_MemWrite || EX_MEM_MemRead) begin
      if (EX_MEM_ByteControl)      misaligned = 1'b0;
      else if (EX_MEM_HalfControl) misaligned = lane[0];
      else                         misaligned = (lane != 2'b00);
    end
  end

  // A simultaneous read+write is a store; the read half is ignored.
  assign store_req = EX_MEM_MemWrite & ~misaligned;
  assign load_req  = EX_MEM_MemRead & ~EX_MEM_MemWrite & ~misaligned;

  always_comb begin
    if (EX_MEM_ByteControl)      store_be = 4'b0001 << lane;
    else if (EX_MEM_HalfControl) store_be = 4'b0011 << lane;
    else                         store_be = 4'b1111;
  end

  // Shifting by the lane puts the value in its byte lanes; be masks the rest.
  assign store_data = EX_MEM_rt_val << {lane, 3'b000};

  // ---------------------------------------------------------------------------
  // Store buffer
  // ---------------------------------------------------------------------------
  logic [AW-1:0]       sb_idx_mem  [SB_DEPTH];
  logic [3:0]          sb_be_mem   [SB_DEPTH];
  logic [31:0]         sb_data_mem [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_valid_reg;
  logic [SB_DEPTH-1:0] sb_valid_next;
  logic [SB_DEPTH-1:0] hit_vec;
  logic [PW-1:0]       head_reg;
  logic [PW-1:0]       tail_reg;
  logic [CW-1:0]       count_reg;
  logic [CW-1:0]       count_next;

  logic load_hit;
  logic load_acc;
  logic drain;
  logic sb_full;
  logic store_stall;
  logic push;

  genvar gi;
  generate
    for (gi = 0; gi < SB_DEPTH; gi++) begin : g_hit
      assign hit_vec[gi] = sb_valid_reg[gi] & (sb_idx_mem[gi] == word_idx);
    end
  endgenerate

  assign load_hit    = |hit_vec;
  // A hitting load waits for every matching entry to drain; no forwarding.
  assign load_acc    = load_req & ~load_hit;
  // The port drains whenever no load owns it, stalled-load cycles included.
  assign drain       = (count_reg != '0) & ~load_acc;
  assign sb_full     = (count_reg == CW'(SB_DEPTH));
  assign store_stall = store_req & sb_full & ~drain;
  assign push        = store_req & ~store_stall;

  assign MEM_Stall   = (load_req & load_hit) | store_stall;
  assign MEM_SBEmpty = (count_reg == '0);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(SB_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Pop is applied before push so a push into the slot being drained
  // (full buffer, drain cycle) leaves that slot valid.
  always_comb begin
    sb_valid_next = sb_valid_reg;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (drain && head_reg == PW'(i)) sb_valid_next[i] = 1'b0;
      if (push  && tail_reg == PW'(i)) sb_valid_next[i] = 1'b1;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, drain})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sb_valid_reg <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
    end else begin
      sb_valid_reg <= sb_valid_next;
      count_reg    <= count_next;
      if (drain) head_reg <= ptr_inc(head_reg);
      if (push)  tail_reg <= ptr_inc(tail_reg);
    end
  end

  // Entry payload needs no reset: the valid bits qualify it.
  always_ff @(posedge Clk) begin
    if (push) begin
      sb_idx_mem[tail_reg]  <= word_idx;
      sb_be_mem[tail_reg]   <= store_be;
      sb_data_mem[tail_reg] <= store_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Single-port RAM: one drain write or one load read per cycle
  // ---------------------------------------------------------------------------
  logic [31:0]   ram [MEM_DEPTH];
  logic [31:0]   rd_word_reg;
  logic [AW-1:0] head_idx;
  logic [3:0]    head_be;
  logic [31:0]   head_data;

  assign head_idx  = sb_idx_mem[head_reg];
  assign head_be   = sb_be_mem[head_reg];
  assign head_data = sb_data_mem[head_reg];

  always_ff @(posedge Clk) begin
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (head_be[b]) ram[head_idx][b*8 +: 8] <= head_data[b*8 +: 8];
      end
    end
    if (load_acc) rd_word_reg <= ram[word_idx];
  end

  // ---------------------------------------------------------------------------
  // Load result path and status pulses
  // ---------------------------------------------------------------------------
  logic [1:0] ld_lane_reg;
  logic       ld_half_reg;
  logic       ld_byte_reg;
  logic       ld_unsigned_reg;
  logic       rd_loaded_reg;  // a load has completed since reset
  logic       read_valid_reg;
  logic       addr_error_reg;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ld_lane_reg     <= 2'b00;
      ld_half_reg     <= 1'b0;
      ld_byte_reg     <= 1'b0;
      ld_unsigned_reg <= 1'b0;
      rd_loaded_reg   <= 1'b0;
      read_valid_reg  <= 1'b0;
      addr_error_reg  <= 1'b0;
    end else begin
      read_valid_reg <= load_acc;
      addr_error_reg <= misaligned;
      if (load_acc) begin
        ld_lane_reg     <= lane;
        ld_half_reg     <= EX_MEM_HalfControl & ~EX_MEM_ByteControl;
        ld_byte_reg     <= EX_MEM_ByteControl;
        ld_unsigned_reg <= EX_MEM_Unsigned;
        rd_loaded_reg   <= 1'b1;
      end
    end
  end

  // The RAM output register has no reset, so the result is forced to zero
  // until the first load after reset completes.
  logic [31:0] rd_shifted;
  logic [31:0] rd_extended;

  assign rd_shifted = rd_word_reg >> {ld_lane_reg, 3'b000};

  always_comb begin
    if (ld_byte_reg)
      rd_extended = ld_unsigned_reg ? {24'b0, rd_shifted[7:0]}
                                    : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
    else if (ld_half_reg)
      rd_extended = ld_unsigned_reg ? {16'b0, rd_shifted[15:0]}
                                    : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
    else
      rd_extended = rd_word_reg;
  end

  assign MEM_ReadData  = rd_loaded_reg ? rd_extended : 32'h0;
  assign MEM_ReadValid = read_valid_reg;
  assign MEM_AddrError = addr_error_reg;

endmodule
